// File: rtl/exec_muldiv_if.sv
// Request/response bundle of the iterative multiply/divide unit.
// The slave modport is the unit itself; the master modport is the issuing stage.
interface exec_muldiv_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             valid_i;
  logic             ready_o;
  logic [2:0]       op_i;
  logic [XLEN-1:0]  a_i;
  logic [XLEN-1:0]  b_i;
  logic [TAG_W-1:0] tag_i;
  logic             kill_i;
  logic             valid_o;
  logic             ready_i;
  logic [XLEN-1:0]  result_o;
  logic [TAG_W-1:0] tag_o;
  logic             busy_o;

  modport slave (
    input  valid_i, op_i, a_i, b_i, tag_i, kill_i, ready_i,
    output ready_o, valid_o, result_o, tag_o, busy_o
  );

  modport master (
    output valid_i, op_i, a_i, b_i, tag_i, kill_i, ready_i,
    input  ready_o, valid_o, result_o, tag_o, busy_o
  );
endinterface

// File: rtl/exec_muldiv.sv
// Iterative RV32M multiply/divide execute slot: radix-2^MUL_STEP shift-add multiply,
// restoring divide. Define MULDIV_FASTPATH_EN to enable early completion of trivial ops.
module exec_muldiv #(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 2,
  parameter int TAG_W    = 5
) (
  input logic         clk_i,
  input logic         rst_n_i,
  exec_muldiv_if.slave bus
);

  localparam int CNT_W    = $clog2(XLEN) + 1;
  localparam int MUL_ITER = XLEN / MUL_STEP;
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_count;
  logic [1:0]         r_opLo;
  logic [TAG_W-1:0]   r_tag;
  logic               r_valid;
  logic [XLEN-1:0]    r_result;
  logic [TAG_W-1:0]   r_tagOut;
  logic [2*XLEN-1:0]  r_prod;
  logic [2*XLEN-1:0]  r_mcand;
  logic [XLEN-1:0]    r_mplier;
  logic               r_neg;
  logic [XLEN-1:0]    r_quo;
  logic [XLEN-1:0]    r_rem;
  logic [XLEN-1:0]    r_divisor;
  logic               r_qNeg;
  logic               r_rNeg;

  logic               w_accept;
  logic               w_isDiv;
  logic               w_isRem;
  logic               w_aSigned;
  logic               w_bSigned;
  logic               w_aNeg;
  logic               w_bNeg;
  logic [XLEN-1:0]    w_aMag;
  logic [XLEN-1:0]    w_bMag;
  logic               w_special;
  logic [XLEN-1:0]    w_specialRes;
  logic [2*XLEN-1:0]  w_partial;
  logic [2*XLEN-1:0]  w_prodNext;
  logic [2*XLEN-1:0]  w_prodFinal;
  logic [XLEN-1:0]    w_mulOut;
  logic [XLEN:0]      w_divShift;
  logic [XLEN:0]      w_divDiff;
  logic               w_divFits;
  logic [XLEN-1:0]    w_remNext;
  logic [XLEN-1:0]    w_quoNext;
  logic [XLEN-1:0]    w_divOut;

  assign w_accept  = bus.valid_i & (r_state == S_IDLE) & ~bus.kill_i;
  assign w_isDiv   = bus.op_i[2];
  assign w_isRem   = bus.op_i[1];

  // MUL low word is sign-agnostic, so it shares the signed-signed path with MULH.
  assign w_aSigned = w_isDiv ? ~bus.op_i[0] : (bus.op_i[1:0] != 2'b11);
  assign w_bSigned = w_isDiv ? ~bus.op_i[0] : ~bus.op_i[1];
  assign w_aNeg    = w_aSigned & bus.a_i[XLEN-1];
  assign w_bNeg    = w_bSigned & bus.b_i[XLEN-1];
  assign w_aMag    = w_aNeg ? -bus.a_i : bus.a_i;
  assign w_bMag    = w_bNeg ? -bus.b_i : bus.b_i;

  always_comb begin
    w_special    = 1'b0;
    w_specialRes = '0;
    if (w_isDiv) begin
      if (bus.b_i == '0) begin
        w_special    = 1'b1;
        w_specialRes = w_isRem ? bus.a_i : '1;
      end else if (~bus.op_i[0] && (bus.a_i == XMIN) && (bus.b_i == '1)) begin
        w_special    = 1'b1;
        w_specialRes = w_isRem ? '0 : bus.a_i;
      end
`ifdef MULDIV_FASTPATH_EN
      else if (w_aMag < w_bMag) begin
        w_special    = 1'b1;
        w_specialRes = w_isRem ? bus.a_i : '0;
      end
`endif
    end
`ifdef MULDIV_FASTPATH_EN
    else if ((bus.a_i == '0) || (bus.b_i == '0)) begin
      w_special    = 1'b1;
      w_specialRes = '0;
    end
`endif
  end

  always_comb begin
    w_partial = '0;
    for (int j = 0; j < MUL_STEP; j++) begin
      if (r_mplier[j]) w_partial = w_partial + (r_mcand << j);
    end
  end

  assign w_prodNext  = r_prod + w_partial;
  assign w_prodFinal = r_neg ? -w_prodNext : w_prodNext;
  assign w_mulOut    = (r_opLo == 2'b00) ? w_prodFinal[XLEN-1:0] : w_prodFinal[2*XLEN-1:XLEN];

  // Remainder stays below the divisor, so one extra bit absorbs the shift-in.
  assign w_divShift = {r_rem, r_quo[XLEN-1]};
  assign w_divDiff  = w_divShift - {1'b0, r_divisor};
  assign w_divFits  = ~w_divDiff[XLEN];
  assign w_remNext  = w_divFits ? w_divDiff[XLEN-1:0] : w_divShift[XLEN-1:0];
  assign w_quoNext  = {r_quo[XLEN-2:0], w_divFits};
  assign w_divOut   = r_opLo[1] ? (r_rNeg ? -w_remNext : w_remNext)
                                : (r_qNeg ? -w_quoNext : w_quoNext);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_opLo    <= '0;
      r_tag     <= '0;
      r_valid   <= 1'b0;
      r_result  <= '0;
      r_tagOut  <= '0;
      r_prod    <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_neg     <= 1'b0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_qNeg    <= 1'b0;
      r_rNeg    <= 1'b0;
    end else if (bus.kill_i) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_opLo <= bus.op_i[1:0];
            r_tag  <= bus.tag_i;
            if (w_special) begin
              r_state  <= S_DONE;
              r_valid  <= 1'b1;
              r_result <= w_specialRes;
              r_tagOut <= bus.tag_i;
            end else if (w_isDiv) begin
              r_state   <= S_DIV;
              r_count   <= CNT_W'(XLEN);
              r_quo     <= w_aMag;
              r_rem     <= '0;
              r_divisor <= w_bMag;
              r_qNeg    <= w_aNeg ^ w_bNeg;
              r_rNeg    <= w_aNeg;
            end else begin
              r_state  <= S_MUL;
              r_count  <= CNT_W'(MUL_ITER);
              r_prod   <= '0;
              r_mcand  <= {{XLEN{1'b0}}, w_aMag};
              r_mplier <= w_bMag;
              r_neg    <= w_aNeg ^ w_bNeg;
            end
          end
        end
        S_MUL: begin
          r_prod   <= w_prodNext;
          r_mcand  <= r_mcand << MUL_STEP;
          r_mplier <= r_mplier >> MUL_STEP;
          r_count  <= r_count - CNT_W'(1);
          if (r_count == CNT_W'(1)) begin
            r_state  <= S_DONE;
            r_valid  <= 1'b1;
            r_result <= w_mulOut;
            r_tagOut <= r_tag;
          end
        end
        S_DIV: begin
          r_rem   <= w_remNext;
          r_quo   <= w_quoNext;
          r_count <= r_count - CNT_W'(1);
          if (r_count == CNT_W'(1)) begin
            r_state  <= S_DONE;
            r_valid  <= 1'b1;
            r_result <= w_divOut;
            r_tagOut <= r_tag;
          end
        end
        S_DONE: begin
          if (bus.ready_i) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready_o  = (r_state == S_IDLE);
  assign bus.busy_o   = (r_state != S_IDLE);
  assign bus.valid_o  = r_valid;
  assign bus.result_o = r_result;
  assign bus.tag_o    = r_tagOut;

endmodule

// File: tb/tb_exec_muldiv.sv
// Directed self-checking bench for exec_muldiv (XLEN=32, MUL_STEP=2, TAG_W=5).
// The DIVU early-completion vector is only exercised when MULDIV_FASTPATH_EN is defined.
module tb_exec_muldiv;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  logic clk;
  logic rstN;
  int   assertCount;
  int   failCount;

  exec_muldiv_if #(.XLEN(32), .TAG_W(5)) bus ();

  exec_muldiv #(.XLEN(32), .MUL_STEP(2), .TAG_W(5)) dut (
    .clk_i   (clk),
    .rst_n_i (rstN),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", name, observed, expected);
    end
  endtask

  // Issue one op, measure edges to valid_o, optionally stall the consumer, then retire it.
  task automatic applyStimulus(input string name, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] tag,
                               input int expLat, input logic [31:0] expRes, input int holdCycles);
    int cycles;
    checkOutput({name, " ready_o before issue"}, 32'(bus.ready_o), 32'd1);
    bus.op_i    = op;
    bus.a_i     = a;
    bus.b_i     = b;
    bus.tag_i   = tag;
    bus.valid_i = 1'b1;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    bus.a_i     = 32'hDEAD_BEEF;
    bus.b_i     = 32'h1234_5678;
    bus.tag_i   = 5'h1F;
    cycles = 1;
    while (!bus.valid_o && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput({name, " latency"}, 32'(cycles), 32'(expLat));
    checkOutput({name, " result"}, bus.result_o, expRes);
    checkOutput({name, " tag"}, 32'(bus.tag_o), 32'(tag));
    checkOutput({name, " ready_o in DONE"}, 32'(bus.ready_o), 32'd0);
    for (int i = 0; i < holdCycles; i++) begin
      @(posedge clk); #1;
      checkOutput({name, " hold valid_o"}, 32'(bus.valid_o), 32'd1);
      checkOutput({name, " hold result"}, bus.result_o, expRes);
      checkOutput({name, " hold tag"}, 32'(bus.tag_o), 32'(tag));
      checkOutput({name, " hold ready_o"}, 32'(bus.ready_o), 32'd0);
    end
    bus.ready_i = 1'b1;
    @(posedge clk); #1;
    bus.ready_i = 1'b0;
    checkOutput({name, " valid_o after handoff"}, 32'(bus.valid_o), 32'd0);
    checkOutput({name, " ready_o after handoff"}, 32'(bus.ready_o), 32'd1);
  endtask

  initial begin
    int sawValid;
    assertCount = 0;
    failCount   = 0;
    rstN        = 1'b0;
    bus.valid_i = 1'b0;
    bus.op_i    = 3'b000;
    bus.a_i     = '0;
    bus.b_i     = '0;
    bus.tag_i   = '0;
    bus.kill_i  = 1'b0;
    bus.ready_i = 1'b0;

    #12;
    checkOutput("reset ready_o", 32'(bus.ready_o), 32'd1);
    checkOutput("reset valid_o", 32'(bus.valid_o), 32'd0);
    checkOutput("reset busy_o", 32'(bus.busy_o), 32'd0);
    checkOutput("reset result_o", bus.result_o, 32'd0);
    checkOutput("reset tag_o", 32'(bus.tag_o), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk); #1;

    applyStimulus("MUL 7*-3", OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd1, 17, 32'hFFFF_FFEB, 0);
    applyStimulus("MULH min*min", OP_MULH, 32'h8000_0000, 32'h8000_0000, 5'd2, 17, 32'h4000_0000, 0);
    applyStimulus("MULHU max*max", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 17, 32'hFFFF_FFFE, 5);
    applyStimulus("MULHSU -1*2", OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd4, 17, 32'hFFFF_FFFF, 0);
    applyStimulus("DIV -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd5, 33, 32'hFFFF_FFFD, 0);
    applyStimulus("REM -7%2", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd6, 33, 32'hFFFF_FFFF, 0);
    applyStimulus("DIV 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 5'd7, 33, 32'hFFFF_FFFD, 0);
    applyStimulus("REM 7%-2", OP_REM, 32'd7, 32'hFFFF_FFFE, 5'd8, 33, 32'd1, 0);
    applyStimulus("DIVU 100/7", OP_DIVU, 32'd100, 32'd7, 5'd9, 33, 32'd14, 0);
    applyStimulus("REMU 100%7", OP_REMU, 32'd100, 32'd7, 5'd10, 33, 32'd2, 0);
    applyStimulus("DIVU 5/0", OP_DIVU, 32'd5, 32'd0, 5'd11, 1, 32'hFFFF_FFFF, 0);
    applyStimulus("REMU 5%0", OP_REMU, 32'd5, 32'd0, 5'd12, 1, 32'd5, 0);
    applyStimulus("REM ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1, 32'd0, 0);
    applyStimulus("DIV ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1, 32'h8000_0000, 0);

    // Kill ten cycles into a divide: unit must drop back to IDLE and never emit.
    bus.op_i    = OP_DIVU;
    bus.a_i     = 32'd100;
    bus.b_i     = 32'd7;
    bus.tag_i   = 5'd15;
    bus.valid_i = 1'b1;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    checkOutput("kill busy_o before kill", 32'(bus.busy_o), 32'd1);
    bus.kill_i = 1'b1;
    @(posedge clk); #1;
    bus.kill_i = 1'b0;
    checkOutput("kill ready_o", 32'(bus.ready_o), 32'd1);
    checkOutput("kill busy_o", 32'(bus.busy_o), 32'd0);
    checkOutput("kill valid_o", 32'(bus.valid_o), 32'd0);
    sawValid = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.valid_o) sawValid = 1;
    end
    checkOutput("kill no late result", 32'(sawValid), 32'd0);
    applyStimulus("MUL after kill", OP_MUL, 32'd12345, 32'd678, 5'd17, 17, 32'h007F_B6F6, 0);

    // Kill in the same cycle as an issue attempt: op must not be taken.
    bus.op_i    = OP_MUL;
    bus.a_i     = 32'd3;
    bus.b_i     = 32'd4;
    bus.tag_i   = 5'd18;
    bus.valid_i = 1'b1;
    bus.kill_i  = 1'b1;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    bus.kill_i  = 1'b0;
    checkOutput("kill at issue busy_o", 32'(bus.busy_o), 32'd0);
    sawValid = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.valid_o) sawValid = 1;
    end
    checkOutput("kill at issue no result", 32'(sawValid), 32'd0);

    // Kill together with ready_i while in DONE: the result is dropped.
    bus.op_i    = OP_DIVU;
    bus.a_i     = 32'd9;
    bus.b_i     = 32'd0;
    bus.tag_i   = 5'd19;
    bus.valid_i = 1'b1;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    checkOutput("kill in DONE valid_o before", 32'(bus.valid_o), 32'd1);
    bus.ready_i = 1'b1;
    bus.kill_i  = 1'b1;
    @(posedge clk); #1;
    bus.ready_i = 1'b0;
    bus.kill_i  = 1'b0;
    checkOutput("kill in DONE valid_o", 32'(bus.valid_o), 32'd0);
    checkOutput("kill in DONE ready_o", 32'(bus.ready_o), 32'd1);

`ifdef MULDIV_FASTPATH_EN
    applyStimulus("DIVU 3/9 fast", OP_DIVU, 32'd3, 32'd9, 5'd20, 1, 32'd0, 0);
    applyStimulus("REMU 3%9 fast", OP_REMU, 32'd3, 32'd9, 5'd21, 1, 32'd3, 0);
    applyStimulus("MUL 0*x fast", OP_MUL, 32'd0, 32'd55, 5'd22, 1, 32'd0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
